// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage sitting in front of the IF/ID pipeline register.
// Owns the fetch PC, issues in-order requests on a req/gnt/rvalid IMEM port,
// buffers returned words together with their PCs in a small FIFO and presents
// the FIFO head to decode. A REDIRECT from EX squashes everything in flight.
//
// Ports
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   IMEM_REQ/IMEM_ADDR  fetch request and word-aligned address, held until GNT
//   IMEM_GNT            request accepted this cycle
//   IMEM_RVALID/RDATA   in-order read response
//   REDIRECT/_PC        control-flow redirect pulse and target (bits [1:0] ignored)
//   stall_FD            IF/ID hold, head entry is not consumed
//   IF_VALID            head entry valid
//   PC_IF/IDATA_IF/PC4_IF  head PC, instruction and PC+4 (all zero when invalid)
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_GNT,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    input  logic        stall_FD,
    output logic        IF_VALID,
    output logic [31:0] PC_IF,
    output logic [31:0] IDATA_IF,
    output logic [31:0] PC4_IF
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(FIFO_DEPTH);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [31:0]      addr_q, addr_d;
    logic             req_q, req_d;
    logic             stale_q, stale_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]      fifo_pc_d   [FIFO_DEPTH];
    logic [31:0]      fifo_data_q [FIFO_DEPTH];
    logic [31:0]      fifo_data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] wr_en;

    logic        issue, rsp, drop_now, push, pop, if_valid, held;
    logic [31:0] redirect_tgt;
    logic [CNT_W:0] inflight_sum;
    logic        unused_low_bits;

    assign redirect_tgt    = {REDIRECT_PC[31:2], 2'b00};
    assign unused_low_bits = ^REDIRECT_PC[1:0];

    assign issue    = req_q & IMEM_GNT;
    // A response with nothing outstanding is a protocol error; ignoring it
    // also swallows stale responses that straddle a reset.
    assign rsp      = IMEM_RVALID & (outstanding_q != '0);
    assign drop_now = rsp & ((drop_cnt_q != '0) | REDIRECT);
    assign push     = rsp & ~drop_now;
    assign if_valid = (count_q != '0);
    assign pop      = if_valid & ~stall_FD & ~REDIRECT;
    // Request pending and not yet accepted: REQ/ADDR must not move.
    assign held     = req_q & ~IMEM_GNT;

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push & (wr_ptr_q == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(rsp);

        if (REDIRECT) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
        end

        // Everything still owed by IMEM after this cycle belongs to the old
        // path. A request granted later that was pending at the redirect is
        // also old-path, hence the stale flag adding one more drop.
        if (REDIRECT) begin
            drop_cnt_d = outstanding_d;
            stale_d    = held;
            fetch_pc_d = redirect_tgt;
            resp_pc_d  = redirect_tgt;
        end else begin
            drop_cnt_d = drop_cnt_q
                       - CNT_W'(rsp & (drop_cnt_q != '0))
                       + CNT_W'(issue & stale_q);
            stale_d    = stale_q & ~issue;
            fetch_pc_d = (issue & ~stale_q) ? fetch_pc_q + 32'd4 : fetch_pc_q;
            resp_pc_d  = push ? resp_pc_q + 32'd4 : resp_pc_q;
        end

        // Credit counts both words in flight and words buffered, so every
        // response is guaranteed a FIFO slot.
        inflight_sum = {1'b0, outstanding_d} + {1'b0, count_d};
        req_d        = held | (inflight_sum < DEPTH_W);
        addr_d       = held ? addr_q : fetch_pc_d;

        for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_pc_d[i]   = wr_en[i] ? resp_pc_q  : fifo_pc_q[i];
            fifo_data_d[i] = wr_en[i] ? IMEM_RDATA : fifo_data_q[i];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            addr_q        <= RESET_PC;
            req_q         <= 1'b0;
            stale_q       <= 1'b0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            addr_q        <= addr_d;
            req_q         <= req_d;
            stale_q       <= stale_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]   <= fifo_pc_d[i];
                fifo_data_q[i] <= fifo_data_d[i];
            end
        end
    end

    assign IMEM_REQ  = req_q;
    assign IMEM_ADDR = addr_q;
    assign IF_VALID  = if_valid;
    assign PC_IF     = if_valid ? fifo_pc_q[rd_ptr_q]           : 32'd0;
    assign IDATA_IF  = if_valid ? fifo_data_q[rd_ptr_q]         : 32'd0;
    assign PC4_IF    = if_valid ? fifo_pc_q[rd_ptr_q] + 32'd4   : 32'd0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Bench for if_fetch_unit: a cycle table for the directed scenarios, a
// hand-written reset-in-flight sequence, and a randomized run checked against
// an instruction-stream model (expected next PC, IMEM contents, handshake
// stability and in-flight credit).
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT = 1'b0;
    logic        IMEM_RVALID = 1'b0;
    logic [31:0] IMEM_RDATA = 32'd0;
    logic        REDIRECT = 1'b0;
    logic [31:0] REDIRECT_PC = 32'd0;
    logic        stall_FD = 1'b0;
    logic        IF_VALID;
    logic [31:0] PC_IF, IDATA_IF, PC4_IF;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    if_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .CLK(CLK), .RST(RST),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
        .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
        .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC), .stall_FD(stall_FD),
        .IF_VALID(IF_VALID), .PC_IF(PC_IF), .IDATA_IF(IDATA_IF), .PC4_IF(PC4_IF)
    );

    // Contents of the instruction memory as seen by the bench.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic ev, input logic [31:0] ep);
        chk({tag, "_valid"}, 32'(IF_VALID), 32'(ev));
        chk({tag, "_pc"},    PC_IF,    ev ? ep : 32'd0);
        chk({tag, "_pc4"},   PC4_IF,   ev ? ep + 32'd4 : 32'd0);
        chk({tag, "_idata"}, IDATA_IF, ev ? imem_word(ep) : 32'd0);
    endtask

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rpc;
        logic        stall;
        logic        redir;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NVEC = 34;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rpc,
                                input logic st, input logic rd, input logic [31:0] tgt,
                                input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ep);
        vec_t v;
        v.gnt = g; v.rv = rv; v.rpc = rpc; v.stall = st; v.redir = rd; v.tgt = tgt;
        v.e_req = er; v.e_addr = ea; v.e_v = ev; v.e_pc = ep;
        return v;
    endfunction

    // Random-phase model state
    logic [31:0] q_addr [$];
    int          q_cyc  [$];
    logic [31:0] exp_pc;
    logic        prev_req, prev_gnt, prev_redir;
    logic [31:0] prev_addr;
    int          n_deliv;

    initial begin
        //        gnt rv rpc       st rd tgt        req addr      v  pc
        // start-up, gapless fetch
        vecs[0]  = mk(1, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
        vecs[1]  = mk(1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h0,   0, 32'h0);
        vecs[2]  = mk(1, 1, 32'h0,   0, 0, 32'h0,   1, 32'h4,   0, 32'h0);
        vecs[3]  = mk(1, 1, 32'h4,   0, 0, 32'h0,   1, 32'h8,   1, 32'h0);
        vecs[4]  = mk(1, 1, 32'h8,   0, 0, 32'h0,   1, 32'hC,   1, 32'h4);
        // stall for 5 cycles with head PC 0x8, credit runs out
        vecs[5]  = mk(1, 1, 32'hC,   1, 0, 32'h0,   1, 32'h10,  1, 32'h8);
        vecs[6]  = mk(1, 1, 32'h10,  1, 0, 32'h0,   1, 32'h14,  1, 32'h8);
        vecs[7]  = mk(1, 1, 32'h14,  1, 0, 32'h0,   0, 32'h18,  1, 32'h8);
        vecs[8]  = mk(1, 0, 32'h0,   1, 0, 32'h0,   0, 32'h18,  1, 32'h8);
        vecs[9]  = mk(1, 0, 32'h0,   1, 0, 32'h0,   0, 32'h18,  1, 32'h8);
        vecs[10] = mk(1, 0, 32'h0,   0, 0, 32'h0,   0, 32'h18,  1, 32'h8);
        vecs[11] = mk(1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h18,  1, 32'hC);
        vecs[12] = mk(1, 1, 32'h18,  0, 0, 32'h0,   1, 32'h1C,  1, 32'h10);
        vecs[13] = mk(1, 1, 32'h1C,  0, 0, 32'h0,   1, 32'h20,  1, 32'h14);
        // words outstanding, redirect to 0x103 with a grant in the same cycle
        vecs[14] = mk(1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h24,  1, 32'h18);
        vecs[15] = mk(1, 0, 32'h0,   0, 1, 32'h103, 1, 32'h28,  1, 32'h1C);
        vecs[16] = mk(0, 1, 32'h20,  0, 0, 32'h0,   1, 32'h100, 0, 32'h0);
        vecs[17] = mk(1, 1, 32'h24,  0, 0, 32'h0,   1, 32'h100, 0, 32'h0);
        vecs[18] = mk(0, 1, 32'h28,  0, 0, 32'h0,   1, 32'h104, 0, 32'h0);
        vecs[19] = mk(0, 1, 32'h100, 0, 0, 32'h0,   1, 32'h104, 0, 32'h0);
        vecs[20] = mk(0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h104, 1, 32'h100);
        // redirect to 0x40 while a request waits for GNT
        vecs[21] = mk(0, 0, 32'h0,   0, 1, 32'h40,  1, 32'h104, 0, 32'h0);
        vecs[22] = mk(0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h104, 0, 32'h0);
        vecs[23] = mk(1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h104, 0, 32'h0);
        vecs[24] = mk(1, 1, 32'h104, 0, 0, 32'h0,   1, 32'h40,  0, 32'h0);
        vecs[25] = mk(0, 1, 32'h40,  0, 0, 32'h0,   1, 32'h44,  0, 32'h0);
        // RVALID coinciding with REDIRECT
        vecs[26] = mk(1, 0, 32'h0,   1, 0, 32'h0,   1, 32'h44,  1, 32'h40);
        vecs[27] = mk(0, 1, 32'h44,  0, 1, 32'h200, 1, 32'h48,  1, 32'h40);
        vecs[28] = mk(1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h48,  0, 32'h0);
        vecs[29] = mk(0, 1, 32'h48,  0, 0, 32'h0,   1, 32'h200, 0, 32'h0);
        vecs[30] = mk(1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h200, 0, 32'h0);
        vecs[31] = mk(0, 1, 32'h200, 0, 0, 32'h0,   1, 32'h204, 0, 32'h0);
        vecs[32] = mk(1, 0, 32'h0,   1, 0, 32'h0,   1, 32'h204, 1, 32'h200);
        vecs[33] = mk(1, 0, 32'h0,   1, 0, 32'h0,   1, 32'h208, 1, 32'h200);

        // ---------------- reset state ----------------
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_req",  32'(IMEM_REQ), 32'd0);
        chk("reset_addr", IMEM_ADDR, RESET_PC);
        chk_head("reset", 1'b0, 32'd0);
        RST = 1'b0;

        // ---------------- directed table ----------------
        for (int i = 0; i < NVEC; i++) begin
            chk($sformatf("row%0d_req", i),  32'(IMEM_REQ), 32'(vecs[i].e_req));
            chk($sformatf("row%0d_addr", i), IMEM_ADDR, vecs[i].e_addr);
            chk_head($sformatf("row%0d", i), vecs[i].e_v, vecs[i].e_pc);
            $display("[TB] row %0d req=%0b addr=%h valid=%0b pc=%h", i, IMEM_REQ, IMEM_ADDR, IF_VALID, PC_IF);
            IMEM_GNT    = vecs[i].gnt;
            IMEM_RVALID = vecs[i].rv;
            IMEM_RDATA  = vecs[i].rv ? imem_word(vecs[i].rpc) : 32'd0;
            stall_FD    = vecs[i].stall;
            REDIRECT    = vecs[i].redir;
            REDIRECT_PC = vecs[i].tgt;
            @(negedge CLK);
        end

        // ---------------- reset with two requests outstanding ----------------
        IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; stall_FD = 1'b0; REDIRECT = 1'b0;
        RST = 1'b1;
        #1;
        chk("rst_mid_req",  32'(IMEM_REQ), 32'd0);
        chk("rst_mid_addr", IMEM_ADDR, RESET_PC);
        chk_head("rst_mid", 1'b0, 32'd0);
        $display("[TB] reset asserted mid-flight valid=%0b req=%0b", IF_VALID, IMEM_REQ);
        @(negedge CLK);
        RST = 1'b0;
        IMEM_RVALID = 1'b1; IMEM_RDATA = 32'hDEAD_BEEF;      // stray response
        @(negedge CLK);
        chk("stray1_req",  32'(IMEM_REQ), 32'd1);
        chk("stray1_addr", IMEM_ADDR, RESET_PC);
        chk_head("stray1", 1'b0, 32'd0);
        IMEM_RDATA = 32'hCAFE_F00D;                          // second stray response
        @(negedge CLK);
        chk_head("stray2", 1'b0, 32'd0);
        chk("stray2_addr", IMEM_ADDR, RESET_PC);
        IMEM_RVALID = 1'b0; IMEM_GNT = 1'b1;
        @(negedge CLK);
        chk("restart_addr", IMEM_ADDR, RESET_PC + 32'd4);
        chk_head("restart0", 1'b0, 32'd0);
        IMEM_GNT = 1'b0; IMEM_RVALID = 1'b1; IMEM_RDATA = imem_word(RESET_PC);
        @(negedge CLK);
        IMEM_RVALID = 1'b0;
        chk_head("restart1", 1'b1, RESET_PC);
        $display("[TB] restart head pc=%h idata=%h", PC_IF, IDATA_IF);

        // ---------------- randomized run against stream model ----------------
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        exp_pc = RESET_PC;
        prev_req = 1'b0; prev_gnt = 1'b0; prev_redir = 1'b0; prev_addr = '0;
        n_deliv = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic        g, st, rd, rv;
            logic [31:0] tgt, rdat;

            if (prev_req && !prev_gnt) begin
                chk("rnd_req_hold",  32'(IMEM_REQ), 32'd1);
                chk("rnd_addr_hold", IMEM_ADDR, prev_addr);
            end
            if (IMEM_REQ) chk("rnd_addr_align", 32'(IMEM_ADDR[1:0]), 32'd0);
            if (prev_redir) chk("rnd_redir_flush", 32'(IF_VALID), 32'd0);
            if (IF_VALID) chk_head("rnd", 1'b1, exp_pc);
            else          chk_head("rnd", 1'b0, 32'd0);

            g   = ($urandom_range(0, 99) < 65);
            st  = ($urandom_range(0, 99) < 25);
            rd  = ($urandom_range(0, 99) < 4);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF4 | 32'($urandom_range(0, 11)))
                                              : $urandom;
            rv = 1'b0; rdat = 32'd0;
            if (q_addr.size() > 0 && q_cyc[0] < cyc && $urandom_range(0, 99) < 70) begin
                rv   = 1'b1;
                rdat = imem_word(q_addr.pop_front());
                void'(q_cyc.pop_front());
            end else if (q_addr.size() == 0 && $urandom_range(0, 99) < 3) begin
                rv   = 1'b1;
                rdat = $urandom;
            end

            if (IMEM_REQ && g) begin
                q_addr.push_back(IMEM_ADDR);
                q_cyc.push_back(cyc);
                chk("rnd_credit", 32'(q_addr.size() <= FIFO_DEPTH), 32'd1);
            end

            if (rd) begin
                exp_pc = {tgt[31:2], 2'b00};
                $display("[TB] cyc %0d redirect to %h", cyc, exp_pc);
            end else if (IF_VALID && !st) begin
                $display("[TB] cyc %0d deliver pc=%h idata=%h", cyc, PC_IF, IDATA_IF);
                exp_pc = exp_pc + 32'd4;
                n_deliv++;
            end

            prev_req = IMEM_REQ; prev_gnt = g; prev_addr = IMEM_ADDR; prev_redir = rd;
            IMEM_GNT = g; stall_FD = st; REDIRECT = rd; REDIRECT_PC = tgt;
            IMEM_RVALID = rv; IMEM_RDATA = rdat;
            @(negedge CLK);
        end
        chk("rnd_progress", 32'(n_deliv > 150), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
